simple_processor: RTL and testbench



---
 rtl/simple_processor.sv | 130 +++++++++++++
 tb/tb_simple_processor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/simple_processor.sv
// Single-cycle 16-bit load/store processor: 16 registers, carry/sign/zero flags,
// combinational instruction and data reads, stores committed by memory on the next edge.
module simple_processor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_in,
  output logic [WIDTH-1:0] mem_out,
  output logic             we
);

  localparam int NREGS = 16;

  logic [WIDTH-1:0] regs [NREGS];
  logic             flag_c, flag_s, flag_z;

  logic [3:0]       op, rd, rs;
  logic [1:0]       sel_src, sel_dst;
  logic [WIDTH-1:0] op0, op1, aluout, pc_nxt;
  logic signed [WIDTH-1:0] imm_sx;
  logic             alu_c, taken, is_alu, is_branch, flag_upd, reg_we, store;

  // Returns {carry, result}; carry means carry-out, borrow, or last bit shifted out.
  function automatic logic [WIDTH:0] alu(input logic [3:0] opc, input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH:0] ea, eb, ec, t;
    ea = {1'b0, a};
    eb = {1'b0, b};
    ec = {{WIDTH{1'b0}}, cin};
    t  = '0;
    case (opc)
      4'h0:       t = eb;
      4'h1:       t = ea + eb;
      4'h2, 4'hB: t = ea - eb;
      4'h3:       t = {1'b0, a & b};
      4'h4:       t = {1'b0, a | b};
      4'h5:       t = {1'b0, a ^ b};
      4'h6:       t = {1'b0, ~b};
      4'h7:       t = ea << b[3:0];
      4'h8: begin
        t = {a, 1'b0} >> b[3:0];
        t = {t[0], t[WIDTH:1]};
      end
      4'h9:       t = ea + eb + ec;
      4'hA:       t = ea - eb - ec;
      default:    t = '0;
    endcase
    return t;
  endfunction

  assign op      = inst[15:12];
  assign sel_src = inst[11:10];
  assign sel_dst = inst[9:8];
  assign rd      = inst[7:4];
  assign rs      = inst[3:0];
  assign imm_sx  = {{(WIDTH-4){inst[3]}}, inst[3:0]};

  assign op0       = regs[rd];
  assign is_alu    = (op <= 4'hA);
  assign is_branch = (op[3:2] == 2'b11);
  assign flag_upd  = (op >= 4'h1) && (op <= 4'hB);
  assign reg_we    = is_alu && (sel_dst == 2'b00);
  assign store     = is_alu && (sel_dst == 2'b01);

  always_comb begin
    op1 = regs[rs];
    case (sel_src)
      2'b01:   op1 = mem_in;
      2'b10:   op1 = {{(WIDTH-4){1'b0}}, inst[3:0]};
      2'b11:   op1 = imm_sx;
      default: op1 = regs[rs];
    endcase
  end

  assign {alu_c, aluout} = alu(op, op0, op1, flag_c);

  always_comb begin
    mem_addr = regs[rd];
    if (sel_dst != 2'b01 && sel_src == 2'b01)
      mem_addr = regs[rs];
  end

  always_comb begin
    taken = 1'b0;
    case (op)
      4'hC:    taken = 1'b1;
      4'hD:    taken = flag_z;
      4'hE:    taken = flag_c;
      4'hF:    taken = flag_s;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_nxt = pc + 1'b1;
    if (is_branch && taken)
      pc_nxt = op1;
    else if (is_alu && sel_dst == 2'b10)
      pc_nxt = aluout;
  end

  // Reset also masks the store strobe so a write in flight is dropped.
  assign we      = store && !rst;
  assign mem_out = we ? aluout : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      flag_c <= 1'b0;
      flag_s <= 1'b0;
      flag_z <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      pc <= pc_nxt;
      if (reg_we)
        regs[rd] <= aluout;
      if (flag_upd) begin
        flag_c <= alu_c;
        flag_s <= aluout[WIDTH-1];
        flag_z <= (aluout == '0);
      end
    end
  end

endmodule

// File: tb/tb_simple_processor.sv
// Directed bench for simple_processor: instructions are presented on inst each cycle,
// registers are observed through mem_addr and flags through branch outcomes.
`timescale 1ns/1ps
module tb_simple_processor;

  logic        clk = 1'b0;
  logic        rst, we, clr;
  logic [15:0] pc, inst, mem_addr, mem_in, mem_out, epc;
  logic [15:0] dmem [512];
  int          total = 0;
  int          bad = 0;

  simple_processor #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst), .mem_addr(mem_addr),
    .mem_in(mem_in), .mem_out(mem_out), .we(we)
  );

  always #10 clk = ~clk;

  assign mem_in = dmem[mem_addr[8:0]];

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 512; k++) dmem[k] <= 16'h0000;
    end else if (we) begin
      dmem[mem_addr[8:0]] <= mem_out;
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] ss,
                                      input logic [1:0] sd, input logic [3:0] rd,
                                      input logic [3:0] rs);
    return {op, ss, sd, rd, rs};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [15:0] i);
    inst = i;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [15:0] i);
    run(i);
    epc = epc + 16'd1;
    chk("pc_inc", pc, epc);
  endtask

  task automatic jmp(input logic [15:0] i, input logic [15:0] target, input string tag);
    run(i);
    epc = target;
    chk(tag, pc, target);
  endtask

  // Branch to 0xFFFE (sign-extended imm 0xE) so taken/not-taken never coincide.
  task automatic br(input logic [3:0] op, input logic tk, input string tag);
    logic [15:0] e;
    e = tk ? 16'hFFFE : epc + 16'd1;
    run(enc(op, 2'b11, 2'b00, 4'h0, 4'hE));
    epc = e;
    chk(tag, pc, e);
  endtask

  task automatic peek(input logic [3:0] r, input logic [15:0] exp, input string tag);
    inst = enc(4'h0, 2'b10, 2'b11, r, 4'h0);
    #1;
    chk(tag, mem_addr, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b1; inst = 16'h0000; epc = 16'h0000;
    #5;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_we", {15'b0, we}, 16'h0000);
    chk("rst_mem_out", mem_out, 16'h0000);
    @(posedge clk); #1;
    clr = 1'b0; rst = 1'b0;
    chk("rst_pc_hold", pc, 16'h0000);

    step(16'h0000); step(16'h0000); step(16'h0000);
    br(4'hD, 1'b0, "init_z"); br(4'hE, 1'b0, "init_c"); br(4'hF, 1'b0, "init_s");

    step(enc(4'h0, 2'b10, 2'b00, 4'd1, 4'd5));
    peek(4'd1, 16'd5, "mov_imm");
    step(enc(4'h1, 2'b11, 2'b00, 4'd1, 4'hF));
    peek(4'd1, 16'd4, "add_neg1");
    br(4'hE, 1'b1, "add_c1"); br(4'hD, 1'b0, "add_z0"); br(4'hF, 1'b0, "add_s0_wrap");
    step(enc(4'h2, 2'b00, 2'b00, 4'd1, 4'd1));
    peek(4'd1, 16'd0, "sub_self");
    br(4'hD, 1'b1, "sub_z1"); br(4'hE, 1'b0, "sub_c0");

    step(enc(4'h0, 2'b11, 2'b00, 4'd2, 4'hF));
    peek(4'd2, 16'hFFFF, "mov_sx");
    step(enc(4'h1, 2'b10, 2'b00, 4'd2, 4'd1));
    peek(4'd2, 16'h0000, "add_wrap");
    br(4'hD, 1'b1, "wrap_z1"); br(4'hE, 1'b1, "wrap_c1");
    step(enc(4'h9, 2'b10, 2'b00, 4'd3, 4'd0));
    peek(4'd3, 16'd1, "adc");
    br(4'hE, 1'b0, "adc_c0");

    step(enc(4'h0, 2'b10, 2'b00, 4'd4, 4'd1));
    step(enc(4'h7, 2'b10, 2'b00, 4'd4, 4'd8));
    peek(4'd4, 16'h0100, "shl8");
    step(enc(4'h0, 2'b10, 2'b00, 4'd1, 4'd7));
    inst = enc(4'h0, 2'b00, 2'b01, 4'd4, 4'd1); #1;
    chk("st_we", {15'b0, we}, 16'h0001);
    chk("st_addr", mem_addr, 16'h0100);
    chk("st_data", mem_out, 16'h0007);
    step(inst);
    chk("st_mem", dmem[256], 16'h0007);
    inst = enc(4'h0, 2'b01, 2'b00, 4'd5, 4'd4); #1;
    chk("ld_we", {15'b0, we}, 16'h0000);
    chk("ld_addr", mem_addr, 16'h0100);
    step(inst);
    peek(4'd5, 16'h0007, "ld_data");
    inst = enc(4'h1, 2'b01, 2'b01, 4'd4, 4'd0); #1;
    chk("rmw_addr", mem_addr, 16'h0100);
    chk("rmw_data", mem_out, 16'h0107);
    step(inst);
    chk("rmw_mem", dmem[256], 16'h0107);

    step(enc(4'hB, 2'b00, 2'b00, 4'd1, 4'd1));
    peek(4'd1, 16'd7, "cmp_nowrite");
    br(4'hD, 1'b1, "cmp_jz_taken");
    step(enc(4'hB, 2'b10, 2'b00, 4'd1, 4'd0));
    br(4'hD, 1'b0, "cmp_jz_not");
    step(enc(4'h0, 2'b10, 2'b00, 4'd6, 4'hC));
    jmp(enc(4'hC, 2'b00, 2'b00, 4'd0, 4'd6), 16'h000C, "jmp_r6");
    jmp(enc(4'h1, 2'b10, 2'b10, 4'd6, 4'd3), 16'h000F, "jmp_alu");
    peek(4'd6, 16'h000C, "jmp_alu_noreg");

    step(enc(4'h0, 2'b10, 2'b00, 4'd7, 4'd1));
    step(enc(4'h7, 2'b10, 2'b00, 4'd7, 4'hF));
    step(enc(4'h4, 2'b10, 2'b00, 4'd7, 4'd1));
    peek(4'd7, 16'h8001, "or_imm");
    step(enc(4'h7, 2'b10, 2'b00, 4'd7, 4'd1));
    peek(4'd7, 16'h0002, "shl1");
    br(4'hE, 1'b1, "shl1_c1");
    step(enc(4'h8, 2'b10, 2'b00, 4'd7, 4'd0));
    peek(4'd7, 16'h0002, "shr0");
    br(4'hE, 1'b0, "shr0_c0");
    step(enc(4'h8, 2'b10, 2'b00, 4'd7, 4'd2));
    peek(4'd7, 16'h0000, "shr2");
    br(4'hD, 1'b1, "shr2_z1"); br(4'hE, 1'b1, "shr2_c1");

    step(enc(4'h2, 2'b10, 2'b00, 4'd1, 4'd8));
    peek(4'd1, 16'hFFFF, "sub_borrow");
    br(4'hF, 1'b1, "sub_s1");
    step(enc(4'hA, 2'b10, 2'b00, 4'd1, 4'd0));
    peek(4'd1, 16'hFFFE, "sbb");
    br(4'hE, 1'b0, "sbb_c0");
    step(enc(4'h6, 2'b00, 2'b00, 4'd9, 4'd1));
    peek(4'd9, 16'h0001, "not");

    inst = enc(4'h0, 2'b00, 2'b01, 4'd4, 4'd7); #1;
    chk("pre_rst_we", {15'b0, we}, 16'h0001);
    #2; rst = 1'b1; #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_we", {15'b0, we}, 16'h0000);
    chk("arst_mem_out", mem_out, 16'h0000);
    peek(4'd1, 16'h0000, "arst_r1");
    inst = enc(4'h0, 2'b00, 2'b01, 4'd4, 4'd7);
    @(posedge clk); #1;
    chk("arst_nostore", dmem[256], 16'h0107);
    rst = 1'b0; epc = 16'h0000;
    step(16'h0000);
    br(4'hD, 1'b0, "arst_z0"); br(4'hE, 1'b0, "arst_c0"); br(4'hF, 1'b0, "arst_s0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
